// File: rtl/reg_ctrl_if.sv
// Signal bundle between reg_ctrl and its datapath: instruction offer, regfile ports,
// ALU control/result, data-memory handshake and status flags.
interface reg_ctrl_if;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ALU_W   = 3;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic [REG_W-1:0]   read_reg1;
  logic [REG_W-1:0]   read_reg2;
  logic [REG_W-1:0]   read_reg3;
  logic               RegWrite;
  logic [REG_W-1:0]   write_reg;
  logic [DATA_W-1:0]  write_data;
  logic               print_regs;
  logic [ALU_W-1:0]   alu_op;
  logic               alu_src_imm;
  logic [DATA_W-1:0]  imm;
  logic [DATA_W-1:0]  alu_result;
  logic               mem_req;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;
  logic               mem_ready;
  logic               halted;
  logic               illegal;

  // Controller side
  modport master (
    input  instr_valid, instr, alu_result, mem_rdata, mem_ready,
    output instr_ready, read_reg1, read_reg2, read_reg3, RegWrite, write_reg,
           write_data, print_regs, alu_op, alu_src_imm, imm, mem_req, mem_we,
           halted, illegal
  );

  // Datapath / environment side
  modport slave (
    output instr_valid, instr, alu_result, mem_rdata, mem_ready,
    input  instr_ready, read_reg1, read_reg2, read_reg3, RegWrite, write_reg,
           write_data, print_regs, alu_op, alu_src_imm, imm, mem_req, mem_we,
           halted, illegal
  );
endinterface

// File: rtl/reg_ctrl.sv
// Multi-cycle instruction controller: accepts one 16-bit instruction at a time and
// sequences regfile reads, ALU, data memory, writeback, register dump and halt.
module reg_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  reg_ctrl_if.master bus
);
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ALU_W  = 3;

  localparam logic [OP_W-1:0] OP_RTYPE   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDI    = 4'd1;
  localparam logic [OP_W-1:0] OP_LW      = 4'd2;
  localparam logic [OP_W-1:0] OP_SW      = 4'd3;
  localparam logic [OP_W-1:0] OP_BEQ     = 4'd4;
  localparam logic [OP_W-1:0] OP_SYSCALL = 4'd5;
  localparam logic [OP_W-1:0] OP_HALT    = 4'd6;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC, MEM_WAIT, WB, PRINT, HALT
  } state_e;

  state_e            state;
  state_e            state_next;
  logic [OP_W-1:0]   ir_op;
  logic [REG_W-1:0]  ir_rd;
  logic              accept_c;
  logic              illegal_op_c;
  logic [OP_W-1:0]   in_op_c;
  logic [ALU_W-1:0]  alu_op_c;
  logic              alu_src_imm_c;
  logic              instr_ready_next;
  logic              reg_write_next;
  logic              print_next;
  logic              mem_req_next;
  logic              mem_we_next;
  logic              halted_next;

  assign accept_c     = bus.instr_valid && bus.instr_ready && (state == IDLE);
  assign illegal_op_c = (ir_op > OP_HALT);
  assign in_op_c      = bus.instr[15:12];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept_c) state_next = DECODE;
      DECODE: begin
        case (ir_op)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_next = EXEC;
          OP_SYSCALL:                              state_next = PRINT;
          OP_HALT:                                 state_next = HALT;
          default:                                 state_next = IDLE;
        endcase
      end
      EXEC: begin
        case (ir_op)
          OP_RTYPE, OP_ADDI: state_next = WB;
          OP_LW, OP_SW:      state_next = MEM_WAIT;
          default:           state_next = IDLE;
        endcase
      end
      // mem_ready seen while still in EXEC is ignored; completion only counts here
      MEM_WAIT: if (bus.mem_ready) state_next = (ir_op == OP_LW) ? WB : IDLE;
      WB:       state_next = IDLE;
      PRINT:    state_next = IDLE;
      HALT:     state_next = HALT;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they register in step with it
  always_comb begin
    instr_ready_next = 1'b0;
    reg_write_next   = 1'b0;
    print_next       = 1'b0;
    mem_req_next     = 1'b0;
    mem_we_next      = 1'b0;
    halted_next      = 1'b0;
    case (state_next)
      IDLE:     instr_ready_next = 1'b1;
      MEM_WAIT: begin
        mem_req_next = 1'b1;
        mem_we_next  = (ir_op == OP_SW);
      end
      WB:       reg_write_next = (ir_rd != '0);
      PRINT:    print_next     = 1'b1;
      HALT:     halted_next    = 1'b1;
      default:  ;
    endcase
  end

  // ALU control decoded straight from the offered word, latched at accept
  always_comb begin
    alu_op_c      = ALU_ADD;
    alu_src_imm_c = 1'b0;
    case (in_op_c)
      OP_RTYPE:             alu_op_c      = bus.instr[2:0];
      OP_ADDI, OP_LW, OP_SW: alu_src_imm_c = 1'b1;
      OP_BEQ:               alu_op_c      = ALU_SUB;
      default:              ;
    endcase
  end

  // Instruction fields, output registers and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_op           <= '0;
      ir_rd           <= '0;
      bus.instr_ready <= 1'b0;
      bus.read_reg1   <= '0;
      bus.read_reg2   <= '0;
      bus.read_reg3   <= '0;
      bus.RegWrite    <= 1'b0;
      bus.write_reg   <= '0;
      bus.write_data  <= '0;
      bus.print_regs  <= 1'b0;
      bus.alu_op      <= '0;
      bus.alu_src_imm <= 1'b0;
      bus.imm         <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.halted      <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.instr_ready <= instr_ready_next;
      bus.RegWrite    <= reg_write_next;
      bus.print_regs  <= print_next;
      bus.mem_req     <= mem_req_next;
      bus.mem_we      <= mem_we_next;
      bus.halted      <= halted_next;
      if (state == DECODE && illegal_op_c) bus.illegal <= 1'b1;
      if (accept_c) begin
        ir_op           <= in_op_c;
        ir_rd           <= bus.instr[11:9];
        bus.read_reg1   <= bus.instr[8:6];
        bus.read_reg2   <= bus.instr[5:3];
        bus.read_reg3   <= bus.instr[11:9];
        bus.alu_op      <= alu_op_c;
        bus.alu_src_imm <= alu_src_imm_c;
        bus.imm         <= DATA_W'({{2{bus.instr[5]}}, bus.instr[5:0]});
      end
      if (state_next == WB) begin
        bus.write_reg  <= ir_rd;
        bus.write_data <= (state == EXEC) ? bus.alu_result : bus.mem_rdata;
      end
    end
  end
endmodule
